// File: rtl/gb_alu_exq.sv
// gb_alu_exq: execute-result stage; W-form sign extension, branch/jump resolution and a
// 2-entry skid buffer (registered o_ready). Define GB_EXQ_OVF_TRAP_EN for the overflow trap (i_trap_ovf/o_exc).
module gb_alu_exq #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_res,
    input  logic            i_zflag,
    input  logic            i_ltflag,
    input  logic            i_oflag,
`ifdef GB_EXQ_OVF_TRAP_EN
    input  logic            i_trap_ovf,
    output logic            o_exc,
`endif
    input  logic            i_w32,
    input  logic [2:0]      i_br_cond,
    input  logic [XLEN-1:0] i_br_target,
    input  logic [RD_W-1:0] i_rd,
    input  logic            i_rd_we,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res,
    output logic [RD_W-1:0] o_rd,
    output logic            o_rd_we,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [RD_W-1:0] rd;
        logic            we;
`ifdef GB_EXQ_OVF_TRAP_EN
        logic            exc;
`endif
    } entry_t;

    state_t state;
    entry_t m;
    entry_t s;
    entry_t cap;
    logic   taken;
    logic   cap_redirect;
    logic   acc;
    logic   pop;

    // Entries arriving while a redirect is being signalled are in the branch shadow and are dropped.
    assign acc = i_valid & o_ready & ~o_redirect;
    assign pop = o_valid & i_ready;

    always_comb begin
        taken = 1'b0;
        case (i_br_cond)
            3'b001:  taken = i_zflag;
            3'b010:  taken = ~i_zflag;
            3'b011:  taken = 1'b1;
            3'b100:  taken = i_ltflag;
            3'b101:  taken = ~i_ltflag;
            default: taken = 1'b0;
        endcase

        cap     = '0;
        cap.res = i_w32 ? {{(XLEN-32){i_res[31]}}, i_res[31:0]} : i_res;
        cap.rd  = i_rd;
        cap.we  = i_rd_we & (i_rd != '0);
        cap_redirect = taken;
`ifdef GB_EXQ_OVF_TRAP_EN
        cap.exc      = i_trap_ovf & i_oflag;
        cap.we       = cap.we & ~cap.exc;
        cap_redirect = taken & ~cap.exc;
`endif
    end

`ifndef GB_EXQ_OVF_TRAP_EN
    logic unused_oflag;
    assign unused_oflag = i_oflag;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= EMPTY;
            o_valid       <= 1'b0;
            o_ready       <= 1'b1;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
            m             <= '0;
            s             <= '0;
        end else begin
            o_redirect <= acc & cap_redirect & ~i_flush;
            if (acc && cap_redirect && !i_flush)
                o_redirect_pc <= i_br_target;

            if (i_flush) begin
                state   <= EMPTY;
                o_valid <= 1'b0;
                o_ready <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (acc) begin
                            m       <= cap;
                            state   <= ONE;
                            o_valid <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (acc && pop) begin
                            m <= cap;
                        end else if (acc) begin
                            s       <= cap;
                            state   <= TWO;
                            o_ready <= 1'b0;
                        end else if (pop) begin
                            state   <= EMPTY;
                            o_valid <= 1'b0;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            m       <= s;
                            state   <= ONE;
                            o_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= EMPTY;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_res   = m.res;
    assign o_rd    = m.rd;
    assign o_rd_we = m.we;
`ifdef GB_EXQ_OVF_TRAP_EN
    assign o_exc   = m.exc;
`endif

endmodule

// File: tb/tb_gb_alu_exq.sv
// Scoreboard bench for gb_alu_exq: directed vectors push expected entries/redirects; a negedge monitor pops and compares.
module tb_gb_alu_exq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic        o_ready;
    logic [63:0] res;
    logic        zflag;
    logic        ltflag;
    logic        oflag;
    logic        w32;
    logic [2:0]  br_cond;
    logic [63:0] br_target;
    logic [4:0]  rd;
    logic        rd_we;
    logic        o_valid;
    logic        ready;
    logic [63:0] o_res;
    logic [4:0]  o_rd;
    logic        o_rd_we;
    logic        o_redirect;
    logic [63:0] o_redirect_pc;
`ifdef GB_EXQ_OVF_TRAP_EN
    logic        trap_ovf;
    logic        o_exc;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
    } exp_t;

    exp_t        eq[$];
    logic [63:0] rq[$];
    exp_t        e;
    logic [63:0] pc_exp;
    logic [63:0] last_pc;

    always #5 clk = ~clk;

    gb_alu_exq #(.XLEN(64), .RD_W(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_valid      (valid),
        .o_ready      (o_ready),
        .i_res        (res),
        .i_zflag      (zflag),
        .i_ltflag     (ltflag),
        .i_oflag      (oflag),
`ifdef GB_EXQ_OVF_TRAP_EN
        .i_trap_ovf   (trap_ovf),
        .o_exc        (o_exc),
`endif
        .i_w32        (w32),
        .i_br_cond    (br_cond),
        .i_br_target  (br_target),
        .i_rd         (rd),
        .i_rd_we      (rd_we),
        .o_valid      (o_valid),
        .i_ready      (ready),
        .o_res        (o_res),
        .o_rd         (o_rd),
        .o_rd_we      (o_rd_we),
        .o_redirect   (o_redirect),
        .o_redirect_pc(o_redirect_pc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] r, input logic w, input logic [2:0] bc,
                         input logic z, input logic lt, input logic [63:0] tgt,
                         input logic [4:0] d, input logic we);
        valid = v; res = r; w32 = w; br_cond = bc; zflag = z; ltflag = lt;
        br_target = tgt; rd = d; rd_we = we;
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
    endtask

    function automatic void push(input logic [63:0] r, input logic [4:0] d, input logic we, input logic x);
        exp_t t;
        t.res = r; t.rd = d; t.we = we; t.exc = x;
        eq.push_back(t);
    endfunction

    // Monitor: every downstream pop and every redirect pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_redirect) begin
                if (rq.size() == 0) begin
                    check("unexpected_redirect", 64'd1, 64'd0);
                end else begin
                    pc_exp = rq.pop_front();
                    check("redirect_pc", o_redirect_pc, pc_exp);
                end
            end
            if (o_valid && ready) begin
                if (eq.size() == 0) begin
                    check("unexpected_pop", 64'd1, 64'd0);
                end else begin
                    e = eq.pop_front();
                    check("pop_res", o_res, e.res);
                    check("pop_rd", {59'd0, o_rd}, {59'd0, e.rd});
                    check("pop_rd_we", {63'd0, o_rd_we}, {63'd0, e.we});
`ifdef GB_EXQ_OVF_TRAP_EN
                    check("pop_exc", {63'd0, o_exc}, {63'd0, e.exc});
`endif
                end
            end
        end
    end

    // {br_cond, zflag, ltflag, taken} with hand-resolved outcomes
    logic [5:0] br_tab [9] = '{
        {3'b100, 1'b0, 1'b0, 1'b0},
        {3'b100, 1'b0, 1'b1, 1'b1},
        {3'b111, 1'b1, 1'b1, 1'b0},
        {3'b010, 1'b0, 1'b0, 1'b1},
        {3'b010, 1'b1, 1'b0, 1'b0},
        {3'b011, 1'b0, 1'b0, 1'b1},
        {3'b101, 1'b0, 1'b0, 1'b1},
        {3'b101, 1'b0, 1'b1, 1'b0},
        {3'b000, 1'b1, 1'b1, 1'b0}
    };

    initial begin
        rst = 1'b1; flush = 1'b0; ready = 1'b0; oflag = 1'b0;
`ifdef GB_EXQ_OVF_TRAP_EN
        trap_ovf = 1'b0;
`endif
        idle();
        last_pc = 64'h0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_ready", {63'd0, o_ready}, 64'd1);
        check("rst_redirect", {63'd0, o_redirect}, 64'd0);
        check("rst_res", o_res, 64'd0);
        check("rst_rd", {59'd0, o_rd}, 64'd0);
        check("rst_rd_we", {63'd0, o_rd_we}, 64'd0);
        check("rst_pc", o_redirect_pc, 64'd0);

        // W-form sign extension, single-cycle latency
        ready = 1'b1;
        drive(1'b1, 64'h0000_0000_8000_0000, 1'b1, 3'b000, 1'b0, 1'b0, 64'h0, 5'd5, 1'b1);
        push(64'hFFFF_FFFF_8000_0000, 5'd5, 1'b1, 1'b0);
        tick();
        idle();
        check("lat_valid", {63'd0, o_valid}, 64'd1);
        check("lat_res", o_res, 64'hFFFF_FFFF_8000_0000);
        tick();

        // Back-to-back: rd==0 suppresses write; positive W-form; 64-bit passthrough
        drive(1'b1, 64'h0000_0000_0000_1234, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1);
        push(64'h0000_0000_0000_1234, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 1'b1, 3'b000, 1'b0, 1'b0, 64'h0, 5'd31, 1'b0);
        push(64'h0000_0000_7FFF_FFFF, 5'd31, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd7, 1'b1);
        push(64'hDEAD_BEEF_0123_4567, 5'd7, 1'b1, 1'b0);
        tick();
        idle();
        tick(); tick();

        // Skid: A in M, B in S, C refused, then drain in order
        ready = 1'b0;
        drive(1'b1, 64'hA, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1);
        push(64'hA, 5'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'hB, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd2, 1'b1);
        push(64'hB, 5'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'hC, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd3, 1'b1);
        push(64'hC, 5'd3, 1'b1, 1'b0);
        tick();
        check("two_ready", {63'd0, o_ready}, 64'd0);
        check("two_valid", {63'd0, o_valid}, 64'd1);
        check("two_res_a", o_res, 64'hA);
        ready = 1'b1;
        tick();
        check("two_to_one_ready", {63'd0, o_ready}, 64'd1);
        tick();
        idle();
        tick(); tick();

        // Taken EQ branch, following entry is in the shadow and discarded
        drive(1'b1, 64'h11, 1'b0, 3'b001, 1'b1, 1'b0, 64'h8000_1000, 5'd2, 1'b1);
        push(64'h11, 5'd2, 1'b1, 1'b0);
        rq.push_back(64'h8000_1000);
        last_pc = 64'h8000_1000;
        tick();
        drive(1'b1, 64'h22, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd3, 1'b1);
        check("eq_redirect", {63'd0, o_redirect}, 64'd1);
        tick();
        idle();
        check("eq_redirect_pulse", {63'd0, o_redirect}, 64'd0);
        tick(); tick();

        // Branch condition table
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 64'h100 + 64'(i), 1'b0, br_tab[i][5:3], br_tab[i][2], br_tab[i][1],
                  64'h4000 + 64'(i) * 64'h10, 5'd4, 1'b1);
            push(64'h100 + 64'(i), 5'd4, 1'b1, 1'b0);
            if (br_tab[i][0]) begin
                rq.push_back(64'h4000 + 64'(i) * 64'h10);
                last_pc = 64'h4000 + 64'(i) * 64'h10;
            end
            tick();
            idle();
            check("br_redirect", {63'd0, o_redirect}, {63'd0, br_tab[i][0]});
            check("br_pc_hold", o_redirect_pc, last_pc);
            tick(); tick();
        end

        // Flush in TWO together with a valid jump
        ready = 1'b0;
        drive(1'b1, 64'h55, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd8, 1'b1);
        tick();
        drive(1'b1, 64'h66, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd9, 1'b1);
        tick();
        drive(1'b1, 64'h77, 1'b0, 3'b011, 1'b0, 1'b0, 64'h9999, 5'd10, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("flush_valid", {63'd0, o_valid}, 64'd0);
        check("flush_ready", {63'd0, o_ready}, 64'd1);
        check("flush_redirect", {63'd0, o_redirect}, 64'd0);
        ready = 1'b1;
        tick(); tick();

        // Flush in ONE with an acceptable jump: no capture, no redirect
        ready = 1'b0;
        drive(1'b1, 64'h88, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd11, 1'b1);
        tick();
        drive(1'b1, 64'h99, 1'b0, 3'b011, 1'b0, 1'b0, 64'h7777, 5'd12, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("flush1_valid", {63'd0, o_valid}, 64'd0);
        check("flush1_redirect", {63'd0, o_redirect}, 64'd0);
        check("flush1_pc", o_redirect_pc, last_pc);
        tick();

        // Overflow flag alone does not trap; jump still redirects and writes
        ready = 1'b1;
        oflag = 1'b1;
        drive(1'b1, 64'hAB, 1'b0, 3'b011, 1'b0, 1'b0, 64'h6000, 5'd13, 1'b1);
        push(64'hAB, 5'd13, 1'b1, 1'b0);
        rq.push_back(64'h6000);
        last_pc = 64'h6000;
        tick();
        idle();
        oflag = 1'b0;
        check("ovf_notrap_redirect", {63'd0, o_redirect}, 64'd1);
        tick(); tick();

`ifdef GB_EXQ_OVF_TRAP_EN
        // Trapping overflow: exception, no write, no redirect
        oflag = 1'b1;
        trap_ovf = 1'b1;
        drive(1'b1, 64'hCD, 1'b0, 3'b011, 1'b0, 1'b0, 64'h1234_0000, 5'd6, 1'b1);
        push(64'hCD, 5'd6, 1'b0, 1'b1);
        tick();
        idle();
        oflag = 1'b0;
        trap_ovf = 1'b0;
        check("trap_redirect", {63'd0, o_redirect}, 64'd0);
        check("trap_exc", {63'd0, o_exc}, 64'd1);
        tick(); tick();
`endif

        // Reset mid-operation drops held entries
        ready = 1'b0;
        drive(1'b1, 64'hEE, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 5'd14, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", {63'd0, o_valid}, 64'd0);
        check("midrst_ready", {63'd0, o_ready}, 64'd1);
        check("midrst_res", o_res, 64'd0);
        check("midrst_pc", o_redirect_pc, 64'd0);
        ready = 1'b1;
        tick(); tick();

        check("sb_entries_left", 64'(eq.size()), 64'd0);
        check("sb_redirects_left", 64'(rq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
